// File: rtl/mul_share_pkg.sv
// mul_share_pkg: shared widths and the in-flight tag type for mul_share_ctrl.
package mul_share_pkg;
  localparam int OP_W = 16;
  localparam int PROD_W = 32;
  localparam int CNT_W = 16;
  // id field sized for the largest supported requester count (8)
  localparam int ID_W = 3;
  typedef struct packed {
    logic valid;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/mul_share_ctrl_rr_pick.sv
// rr_pick: combinational round-robin picker; searches from last+1 upward, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] id,
  output logic          any
);
  logic [IW-1:0] idx;
  always_comb begin
    idx = '0;
    id = '0;
    any = 1'b0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % N);
      if (elig[idx]) begin
        any = 1'b1;
        id = idx;
      end
    end
    grant = any ? N'(1) << id : '0;
  end
endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin sharing of one registered 16x16 multiplier among NREQ requesters.
// Define MUL_SHARE_STATS_EN to add the per-requester grant counters on grant_cnt.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OP_W-1:0]   req_a,
  input  logic [NREQ*OP_W-1:0]   req_b,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [NREQ*PROD_W-1:0] rsp_data,
  output logic [OP_W-1:0]        mul_a,
  output logic [OP_W-1:0]        mul_b,
  input  logic [PROD_W-1:0]      mul_result
`ifdef MUL_SHARE_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0]  grant_cnt
`endif
);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0] busy, grant;
  logic [IW-1:0] last, pick_id;
  logic pick_any;
  tag_t tag_in, tag_out;
  tag_t [MUL_LAT:0] pipe;

  rr_pick #(.N(NREQ)) u_pick (
    .elig (req_valid & ~busy),
    .last (last),
    .grant(grant),
    .id   (pick_id),
    .any  (pick_any)
  );

  assign req_ready = grant & {NREQ{rst_n}};
  assign tag_in = '{valid: pick_any, id: ID_W'(pick_id)};
  assign tag_out = pipe[MUL_LAT];

  // tag pipeline lines up with the operand register plus MUL_LAT multiplier stages
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last <= IW'(NREQ - 1);
      mul_a <= '0;
      mul_b <= '0;
      pipe <= '0;
    end else begin
      pipe <= {pipe[MUL_LAT-1:0], tag_in};
      if (pick_any) begin
        last <= pick_id;
        mul_a <= OP_W'(req_a >> (OP_W * int'(pick_id)));
        mul_b <= OP_W'(req_b >> (OP_W * int'(pick_id)));
      end
    end

  // one outstanding op per requester, so a returning product never hits a valid slot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
    end else
      for (int k = 0; k < NREQ; k++) begin
        if (grant[k]) busy[k] <= 1'b1;
        else if (rsp_valid[k] && rsp_ready[k]) busy[k] <= 1'b0;
        if (tag_out.valid && tag_out.id == ID_W'(k)) begin
          rsp_valid[k] <= 1'b1;
          rsp_data[k*PROD_W +: PROD_W] <= mul_result;
        end else if (rsp_ready[k]) rsp_valid[k] <= 1'b0;
      end

`ifdef MUL_SHARE_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) grant_cnt <= '0;
    else
      for (int k = 0; k < NREQ; k++)
        if (grant[k]) grant_cnt[k*CNT_W +: CNT_W] <= grant_cnt[k*CNT_W +: CNT_W] + 1'b1;
`endif
endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: randomized scoreboard bench for mul_share_ctrl against a spec-level model.
`timescale 1ns/1ps
module tb_mul_share_ctrl;
  localparam int NREQ = 4;
  localparam int MUL_LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0, rsp_ready = '0, req_ready, rsp_valid;
  logic [NREQ*16-1:0] req_a = '0, req_b = '0;
  logic [NREQ*32-1:0] rsp_data;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_result;
`ifdef MUL_SHARE_STATS_EN
  logic [NREQ*16-1:0] grant_cnt;
`endif

  mul_share_ctrl #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_result(mul_result)
`ifdef MUL_SHARE_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // trusted external multiplier with MUL_LAT register stages
  logic [31:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= {16'b0, mul_a} * {16'b0, mul_b};
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_result = mpipe[MUL_LAT-1];

  typedef struct {
    logic [31:0] p;
    int due;
  } exp_t;
  exp_t exp_q [NREQ][$];
  bit seen [NREQ];
  int cnt_m [NREQ];
  int n_chk = 0, n_fail = 0, cyc = 0, last_m = NREQ - 1;
  logic [15:0] ema = '0, emb = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // arbitration model: a requester is busy while its product is still owed
  always @(negedge clk) begin
    logic [NREQ-1:0] g;
    int w, j;
    exp_t e;
    if (!rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        exp_q[k].delete();
        seen[k] = 0;
        cnt_m[k] = 0;
      end
      last_m = NREQ - 1;
      ema = '0;
      emb = '0;
      check("reset req_ready", req_ready, 0);
      check("reset rsp_valid", rsp_valid, 0);
      check("reset rsp_data", rsp_data, 0);
      check("reset mul_a", mul_a, 0);
      check("reset mul_b", mul_b, 0);
    end else begin
      check("mul_a", mul_a, ema);
      check("mul_b", mul_b, emb);
`ifdef MUL_SHARE_STATS_EN
      for (int k = 0; k < NREQ; k++) check("grant_cnt", grant_cnt[k*16 +: 16], cnt_m[k] & 16'hffff);
`endif
      g = '0;
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        j = (last_m + k) % NREQ;
        if (w < 0 && req_valid[j] && exp_q[j].size() == 0) w = j;
      end
      if (w >= 0) g[w] = 1'b1;
      check("req_ready", req_ready, g);
      if (w >= 0) begin
        e.p = 32'(req_a[w*16 +: 16]) * 32'(req_b[w*16 +: 16]);
        e.due = cyc + MUL_LAT + 2;
        exp_q[w].push_back(e);
        last_m = w;
        ema = req_a[w*16 +: 16];
        emb = req_b[w*16 +: 16];
        cnt_m[w]++;
      end
    end
  end

  // response monitor
  always @(negedge clk) begin
    #1;
    if (rst_n)
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i]) begin
          if (exp_q[i].size() == 0) check("rsp_valid unexpected", rsp_valid[i], 0);
          else begin
            check("rsp_data", rsp_data[i*32 +: 32], exp_q[i][0].p);
            if (!seen[i]) begin
              check("rsp latency", cyc, exp_q[i][0].due);
              seen[i] = 1;
            end
            if (rsp_ready[i]) begin
              void'(exp_q[i].pop_front());
              seen[i] = 0;
            end
          end
        end else if (exp_q[i].size() != 0 && cyc > exp_q[i][0].due) begin
          check("rsp_valid missing", rsp_valid[i], 1);
          void'(exp_q[i].pop_front());
        end
      end
  end

  logic [NREQ-1:0] fired = '0;

  task automatic step();
    @(negedge clk);
    fired = req_valid & req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  function automatic logic [15:0] rnd_op();
    int s = $urandom_range(0, 5);
    return s == 0 ? 16'h0 : s == 1 ? 16'hffff : 16'($urandom);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && req_valid != '0; n++) begin
      step();
      req_valid &= ~fired;
    end
    repeat (8) step();
  endtask

  initial begin
    rsp_ready = '1;
    repeat (3) step();
    rst_n = 1'b1;
    set_op(0, 16'd3, 16'd5);
    req_valid = 4'b0001;
    drain();
    do_reset();
    set_op(0, 16'd7, 16'd9);
    set_op(1, 16'd0, 16'h1234);
    set_op(2, 16'hffff, 16'hffff);
    set_op(3, 16'd100, 16'd200);
    req_valid = '1;
    drain();
    rsp_ready[0] = 1'b0;
    set_op(0, 16'h1111, 16'd2);
    set_op(1, rnd_op(), rnd_op());
    req_valid = 4'b0011;
    for (int n = 0; n < 24; n++) begin
      if (n == 14) rsp_ready[0] = 1'b1;
      step();
      for (int i = 0; i < 2; i++) if (fired[i]) set_op(i, rnd_op(), rnd_op());
    end
    req_valid = '0;
    repeat (8) step();
    set_op(0, 16'd11, 16'd13);
    set_op(1, 16'd17, 16'd19);
    req_valid = 4'b0011;
    step();
    step();
    req_valid = '0;
    rst_n = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) set_op(i, rnd_op(), rnd_op());
    req_valid = 4'b0111;
    rst_n = 1'b1;
    drain();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] || fired[i]) begin
          req_valid[i] = $urandom_range(0, 3) != 0;
          set_op(i, rnd_op(), rnd_op());
        end
      rsp_ready = NREQ'($urandom) | NREQ'($urandom);
      step();
    end
    req_valid = '0;
    rsp_ready = '1;
    repeat (12) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/mul_share_ctrl.md
# mul_share_ctrl

Round-robin controller that shares one registered 16×16 unsigned multiplier among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier inputs. It tracks in-flight operations with an id pipeline and returns each 32-bit product to the requester that issued it, through a per-requester response register with backpressure. It sits between the compute clients and the shared multiplier instance in the datapath.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `MUL_LAT`, 1: multiplier latency in cycles, from operands at its inputs to a valid `mul_result`; ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: operand pair valid, one bit per requester.
- `req_ready` out NREQ: grant. A transfer occurs when valid and ready are both high.
- `req_a` in NREQ*16: packed operand A; requester i uses bits [16i+15:16i].
- `req_b` in NREQ*16: packed operand B, same packing.
- `rsp_valid` out NREQ: product available for requester i.
- `rsp_ready` in NREQ: requester i accepts its product.
- `rsp_data` out NREQ*32: packed products; requester i uses bits [32i+31:32i].
- `mul_a` out 16: registered operand A to the multiplier.
- `mul_b` out 16: registered operand B to the multiplier.
- `mul_result` in 32: multiplier product.
- `grant_cnt` out NREQ*16: per-requester grant counters. Present only with `MUL_SHARE_STATS_EN`.

## Operation
- At most one operation is outstanding per requester.
  - `busy[i]` is set on a grant to i.
  - `busy[i]` clears when the rsp_valid/rsp_ready transfer for i completes.
- Eligibility: `req_valid[i] && !busy[i]`.
- At most one grant per cycle.
  - The winner is the first eligible index found by searching from `last+1` upward, wrapping modulo NREQ.
  - `last` updates to the winner on each grant.
  - Reset value of `last` is NREQ-1, so requester 0 has priority after reset.
- `req_ready` is combinational from `req_valid` and state. It is one-hot or zero.
- On a grant:
  - `mul_a`/`mul_b` load the winner's operands.
  - A tag {valid, id} enters a shift register of depth `MUL_LAT+1`.
  - Without a grant, `mul_a`/`mul_b` hold their previous value and a null tag enters.
- When a valid tag exits the shift register, `mul_result` is written into slot `rsp_data[id]` and `rsp_valid[id]` is set.
- `rsp_valid[i]` clears on the rsp_valid/rsp_ready transfer for i. Data is stable while valid and not ready.
- Arithmetic is unsigned 16×16→32 with no truncation. The multiplier is trusted.
- Response slot collision is impossible, because of the one-outstanding rule. A slot is never overwritten while valid.
- Simultaneous events:
  - A response transfer for i and a new `req_valid[i]` in the same cycle: i becomes eligible the following cycle, not the same cycle.
  - Grant to i and a response for j≠i are independent.
- Reset, whether asserted idle or mid-operation:
  - All tags, busy bits, response slots and `last` are cleared.
  - In-flight products are discarded and no response is issued.
  - `req_ready` is forced to 0 while `rst_n` is low.

## Timing
- Reset values:
  - `req_ready`, `rsp_valid`, `mul_a`, `mul_b`, `rsp_data`, `grant_cnt`: all 0.
  - `last`: NREQ-1.
- A handshake in cycle t gives:
  - `mul_a`/`mul_b` valid in t+1.
  - `mul_result` valid in t+1+MUL_LAT.
  - `rsp_valid` high in t+2+MUL_LAT. With MUL_LAT=1 that is t+3.
- Peak throughput is one grant per cycle across requesters. Per requester it is one operation per MUL_LAT+3 cycles when `rsp_ready` is held high.

## Configuration
- `MUL_SHARE_STATS_EN` defined:
  - `grant_cnt` port exists.
  - Each 16-bit counter increments on every grant to its requester and wraps 0xFFFF→0.
  - Counters reset to 0.
- Not defined: the port and the counters are absent. All other behaviour is identical.

## Structure
- Shared package `mul_share_pkg` contains:
  - Widths: `OP_W`=16, `PROD_W`=32, `CNT_W`=16.
  - Tag struct type {valid, id[$clog2(NREQ)-1:0]}.
- Sub-module `rr_pick`: a combinational round-robin picker.
  - Inputs: eligible vector, `last`.
  - Outputs: one-hot grant, encoded id, any.
- The multiplier is instantiated outside this block.

## Test plan
- Req0 sends a=3, b=5 in cycle 0 with MUL_LAT=1 → `mul_a`=3 and `mul_b`=5 in cycle 1. `rsp_valid[0]` is high in cycle 3 with `rsp_data[0]`=15.
- All four requesters valid in cycle 0 after reset → grants in cycles 0,1,2,3 to ids 0,1,2,3. Responses follow in cycles 3,4,5,6 with the correct per-id products.
- Req2 sends a=0xFFFF, b=0xFFFF → product 0xFFFE0001. Req1 sends a=0, b=0x1234 → product 0.
- Hold `rsp_ready[0]`=0 after req0's response while req0 and req1 stay valid:
  - req0 is not granted again.
  - req1 keeps being granted.
  - `rsp_data[0]` is stable.
  - Raising `rsp_ready[0]` → req0 is granted the following cycle.
- Assert `rst_n`=0 one cycle after grants to 0 and 1 → no `rsp_valid` ever appears for them. After release, req0 wins first.
- With `MUL_SHARE_STATS_EN` defined, issue 5 grants to req3 → `grant_cnt[3]`=5 and the other counters are 0. A preloaded 0xFFFF counter wraps to 0 on its next grant.
